seg7_scan_ctrl: RTL and testbench

//  Time-multiplexes the shared 7-segment cathode bus across the board's 8 anode-selected digits.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, scan FSM state type and hex-to-segment table for the
// 7-segment scan controller.
package seg7_pkg;

  // All segments off (active-low cathodes), bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // All digit selects off (active-low anodes).
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Active-low segment pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Pure table lookup, no state.
  always_comb begin
    o_seg = hex_to_seg(i_nibble);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment
// display. Each digit slot starts with a blanking interval (anti-ghosting),
// and the display value is snapshotted once per frame so digits never tear.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100_000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned DIGITS    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  output logic [7:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DIGITS - 1);

  // Slot prescaler, digit index and scan state.
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  scan_state_e      r_state;

  // Per-frame snapshot of the datapath inputs.
  logic [31:0]      r_snap_val;
  logic [7:0]       r_snap_en;
  logic [7:0]       r_snap_dp;

  // Registered pin drivers.
  logic [7:0]       r_anode;
  logic [6:0]       r_cathode;
  logic             r_dp;
  logic             r_frame_done;

  // Next-state / next-output nets.
  logic             w_slot_end;
  logic             w_frame_end;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  scan_state_e      w_state_nxt;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg;
  logic [7:0]       w_anode_nxt;
  logic [6:0]       w_cathode_nxt;
  logic             w_dp_nxt;

  assign w_nibble = r_snap_val[{r_idx, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Counter advance and FSM next state; the state tracks the counter value
  // it will sit alongside, so BLANK covers cnt < BLANK_CYC exactly.
  always_comb begin
    w_slot_end  = (r_cnt == CNT_MAX);
    w_frame_end = w_slot_end && (r_idx == IDX_MAX);
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    if (w_slot_end) begin
      w_cnt_nxt = '0;
      w_idx_nxt = r_idx + IDX_W'(1);
    end
    if (w_frame_end) begin
      w_idx_nxt = '0;
    end
    w_state_nxt = (w_cnt_nxt < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
  end

  // Output decode from the current (state, idx); registered one cycle later.
  always_comb begin
    w_anode_nxt   = ANODE_OFF;
    w_cathode_nxt = SEG_BLANK;
    w_dp_nxt      = 1'b1;
    if (r_state == ST_DRIVE) begin
      w_anode_nxt[r_idx] = ~r_snap_en[r_idx];
      w_cathode_nxt      = w_seg;
      w_dp_nxt           = ~r_snap_dp[r_idx];
    end
  end

  // Slot counter, digit index and FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= ST_BLANK;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Snapshot inputs at the frame boundary only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_snap_val <= '0;
      r_snap_en  <= '0;
      r_snap_dp  <= '0;
    end else if (w_frame_end) begin
      r_snap_val <= value;
      r_snap_en  <= digit_en;
      r_snap_dp  <= dp_in;
    end
  end

  // Registered pin drivers and frame pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_anode      <= ANODE_OFF;
      r_cathode    <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_anode      <= w_anode_nxt;
      r_cathode    <= w_cathode_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  assign anode      = r_anode;
  assign cathode    = r_cathode;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (TICK_DIV=8, BLANK_CYC=2).
module tb_seg7_scan_ctrl;

  localparam int unsigned TD = 8;
  localparam int unsigned BC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] value = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC), .DIGITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .anode      (anode),
    .cathode    (cathode),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance to the next frame_done cycle; ok=0 if it never arrives.
  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic exp_fd;
    reset = 1'b0;
    repeat (5) tick();
    n_cmp++; if (anode !== 8'hFF) begin n_bad++; $display("FAIL rst_anode got=%h exp=ff", anode); end
    n_cmp++; if (cathode !== 7'h7F) begin n_bad++; $display("FAIL rst_cathode got=%h exp=7f", cathode); end
    n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL rst_dp got=%b exp=1", dp); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_fd got=%b exp=0", frame_done); end
    reset = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      exp_fd = (k == 64);
      n_cmp++; if (anode !== 8'hFF) begin n_bad++; $display("FAIL rst_dark k=%0d got=%h exp=ff", k, anode); end
      n_cmp++; if (frame_done !== exp_fd) begin n_bad++; $display("FAIL rst_fd k=%0d got=%b exp=%b", k, frame_done, exp_fd); end
    end
  endtask

  task automatic test_scan();
    bit ok;
    logic [31:0] vv;
    logic [7:0]  dd, exp_an;
    logic [6:0]  exp_cat;
    logic        exp_dp, exp_fd;
    logic [3:0]  nib;
    int idx, c;
    vv = 32'h89ABCDEF; dd = 8'h01;
    value = vv; digit_en = 8'hFF; dp_in = dd;
    wait_fd(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL scan_sync1 got=timeout exp=frame_done"); end
    wait_fd(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL scan_sync2 got=timeout exp=frame_done"); end
    for (int k = 1; k <= 64; k++) begin
      tick();
      idx = (k - 1) / 8; c = (k - 1) % 8;
      nib = vv[idx*4 +: 4];
      exp_an = 8'hFF; exp_cat = 7'h7F; exp_dp = 1'b1;
      if (c >= BC) begin
        exp_an = ~(8'h01 << idx); exp_cat = seg_tbl[nib]; exp_dp = ~dd[idx];
      end
      exp_fd = (k == 64);
      n_cmp++; if (anode !== exp_an) begin n_bad++; $display("FAIL scan_anode k=%0d got=%h exp=%h", k, anode, exp_an); end
      n_cmp++; if (cathode !== exp_cat) begin n_bad++; $display("FAIL scan_cathode k=%0d got=%h exp=%h", k, cathode, exp_cat); end
      n_cmp++; if (dp !== exp_dp) begin n_bad++; $display("FAIL scan_dp k=%0d got=%b exp=%b", k, dp, exp_dp); end
      n_cmp++; if (frame_done !== exp_fd) begin n_bad++; $display("FAIL scan_fd k=%0d got=%b exp=%b", k, frame_done, exp_fd); end
      if (k == 3) begin
        n_cmp++; if (cathode !== 7'h0E || dp !== 1'b0) begin n_bad++; $display("FAIL scan_dig0 got=%h/%b exp=0e/0", cathode, dp); end
      end
      if (k == 59) begin
        n_cmp++; if (cathode !== 7'h00 || dp !== 1'b1) begin n_bad++; $display("FAIL scan_dig7 got=%h/%b exp=00/1", cathode, dp); end
      end
    end
  endtask

  task automatic test_blanking();
    bit ok;
    logic [31:0] vv;
    logic [7:0]  en, exp_an;
    logic [6:0]  exp_cat;
    logic [3:0]  nib;
    int idx, c;
    vv = 32'h01234567; en = 8'h0F;
    value = vv; digit_en = en; dp_in = 8'h00;
    wait_fd(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL blank_sync got=timeout exp=frame_done"); end
    for (int k = 1; k <= 64; k++) begin
      tick();
      idx = (k - 1) / 8; c = (k - 1) % 8;
      nib = vv[idx*4 +: 4];
      exp_an = 8'hFF; exp_cat = 7'h7F;
      if (c >= BC) begin
        exp_cat = seg_tbl[nib];
        if (en[idx]) exp_an = ~(8'h01 << idx);
      end
      n_cmp++; if (anode !== exp_an) begin n_bad++; $display("FAIL blank_anode k=%0d got=%h exp=%h", k, anode, exp_an); end
      n_cmp++; if (cathode !== exp_cat) begin n_bad++; $display("FAIL blank_cathode k=%0d got=%h exp=%h", k, cathode, exp_cat); end
      if (k == 19) begin
        n_cmp++; if (cathode !== 7'h12) begin n_bad++; $display("FAIL blank_dig2 got=%h exp=12", cathode); end
      end
      if (k == 35) begin
        n_cmp++; if (anode !== 8'hFF || cathode !== 7'h30) begin n_bad++; $display("FAIL blank_dig4 got=%h/%h exp=ff/30", anode, cathode); end
      end
    end
  endtask

  task automatic test_tearing();
    bit ok;
    logic [7:0] exp_an;
    logic [6:0] exp_cat;
    logic       exp_fd;
    int idx, c;
    value = 32'h0; digit_en = 8'hFF; dp_in = 8'h00;
    wait_fd(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tear_sync got=timeout exp=frame_done"); end
    for (int k = 1; k <= 128; k++) begin
      tick();
      idx = ((k - 1) % 64) / 8; c = (k - 1) % 8;
      exp_an = 8'hFF; exp_cat = 7'h7F;
      if (c >= BC) begin
        exp_an = ~(8'h01 << idx);
        exp_cat = (k <= 64) ? 7'h40 : 7'h0E;
      end
      exp_fd = (k == 64) || (k == 128);
      n_cmp++; if (anode !== exp_an) begin n_bad++; $display("FAIL tear_anode k=%0d got=%h exp=%h", k, anode, exp_an); end
      n_cmp++; if (cathode !== exp_cat) begin n_bad++; $display("FAIL tear_cathode k=%0d got=%h exp=%h", k, cathode, exp_cat); end
      n_cmp++; if (frame_done !== exp_fd) begin n_bad++; $display("FAIL tear_fd k=%0d got=%b exp=%b", k, frame_done, exp_fd); end
      if (k == 20) value = 32'hFFFFFFFF;
    end
  endtask

  task automatic test_reset_midscan();
    bit ok;
    logic exp_fd;
    wait_fd(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_sync got=timeout exp=frame_done"); end
    repeat (29) tick();
    n_cmp++; if (anode !== 8'hF7) begin n_bad++; $display("FAIL mid_pre_anode got=%h exp=f7", anode); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++; if (anode !== 8'hFF) begin n_bad++; $display("FAIL mid_anode got=%h exp=ff", anode); end
    n_cmp++; if (cathode !== 7'h7F) begin n_bad++; $display("FAIL mid_cathode got=%h exp=7f", cathode); end
    n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL mid_dp got=%b exp=1", dp); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL mid_fd got=%b exp=0", frame_done); end
    for (int k = 1; k <= 64; k++) begin
      tick();
      exp_fd = (k == 64);
      n_cmp++; if (anode !== 8'hFF) begin n_bad++; $display("FAIL mid_dark k=%0d got=%h exp=ff", k, anode); end
      n_cmp++; if (frame_done !== exp_fd) begin n_bad++; $display("FAIL mid_fd k=%0d got=%b exp=%b", k, frame_done, exp_fd); end
    end
    repeat (2) begin
      tick();
      n_cmp++; if (anode !== 8'hFF) begin n_bad++; $display("FAIL mid_resume_blank got=%h exp=ff", anode); end
    end
    tick();
    n_cmp++; if (anode !== 8'hFE) begin n_bad++; $display("FAIL mid_resume_anode got=%h exp=fe", anode); end
    n_cmp++; if (cathode !== 7'h0E) begin n_bad++; $display("FAIL mid_resume_cathode got=%h exp=0e", cathode); end
  endtask

  task automatic test_decode_sweep();
    bit ok;
    for (int n = 0; n < 16; n++) begin
      value = 32'(n);
      wait_fd(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL sweep_sync n=%0d got=timeout exp=frame_done", n); end
      repeat (3) tick();
      n_cmp++; if (anode !== 8'hFE) begin n_bad++; $display("FAIL sweep_anode n=%0d got=%h exp=fe", n, anode); end
      n_cmp++; if (cathode !== seg_tbl[n]) begin n_bad++; $display("FAIL sweep_cathode n=%0d got=%h exp=%h", n, cathode, seg_tbl[n]); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_tearing();
    test_reset_midscan();
    test_decode_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
